// File: rtl/tlb_refill_arbiter_pkg.sv
// Shared MMU definitions for the main-TLB refill arbiter: FSM states, CP0
// maintenance op codes, grant encoding and default parameters.
package tlb_refill_arbiter_pkg;

  localparam int VPN_W            = 20;
  localparam int DEF_STARVE_LIMIT = 3;
  localparam int DEF_RES_W        = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_RESP   = 3'd2,
    ST_MAINT  = 3'd3,
    ST_FLUSH  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_TLBWI = 2'b01,
    OP_TLBWR = 2'b10,
    OP_TLBP  = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2,
    GNT_OP   = 2'd3
  } grant_e;

  typedef enum logic {
    SIDE_INST = 1'b0,
    SIDE_DATA = 1'b1
  } side_e;

  // Code 00 is not a maintenance operation; such requests are never granted.
  function automatic logic op_valid(input logic [1:0] op);
    return op != OP_NONE;
  endfunction

endpackage

// File: rtl/tlb_arb_prio.sv
// Combinational priority pick: maintenance > data > inst, except that a
// starved inst request beats a pending data request.
module tlb_arb_prio
  import tlb_refill_arbiter_pkg::*;
(
  input  logic       op_req_i,
  input  logic [1:0] op_i,
  input  logic       dreq_i,
  input  logic       ireq_i,
  input  logic       starved_i,
  output logic [1:0] grant_o
);

  // NOTE: assigning a default first on every path keeps always_comb free of inferred latches.
  always_comb begin
    grant_o = GNT_NONE;
    if (op_req_i && op_valid(op_i)) begin
      grant_o = GNT_OP;
    end else if (dreq_i && ireq_i && starved_i) begin
      grant_o = GNT_INST;
    end else if (dreq_i) begin
      grant_o = GNT_DATA;
    end else if (ireq_i) begin
      grant_o = GNT_INST;
    end
  end

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Arbitrates inst/data micro-TLB misses and CP0 maintenance ops onto the
// single main-TLB port; outputs decode from registered state and latches.
module tlb_refill_arbiter
  import tlb_refill_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int RES_W        = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  // inst micro-TLB side
  input  logic             ireq_i,
  input  logic [19:0]      ivpn_i,
  output logic             i_done_o,
  output logic             i_hit_o,
  // data micro-TLB side
  input  logic             dreq_i,
  input  logic [19:0]      dvpn_i,
  output logic             d_done_o,
  output logic             d_hit_o,
  output logic [RES_W-1:0] res_out_o,
  // CP0 maintenance
  input  logic             op_req_i,
  input  logic [1:0]       op_i,
  output logic             op_busy_o,
  output logic             op_done_o,
  // main TLB
  output logic             tlb_lk_req_o,
  output logic [19:0]      tlb_lk_vpn_o,
  input  logic             tlb_lk_hit_i,
  input  logic [RES_W-1:0] tlb_lk_res_i,
  output logic             tlb_op_en_o,
  output logic [1:0]       tlb_op_o,
  output logic             utlb_flush_o
);

  localparam int STRK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIMIT);

  arb_state_e          state_q;
  side_e               side_q;
  logic [VPN_W-1:0]    vpn_q;
  tlb_op_e             op_q;
  logic [STRK_W-1:0]   streak_q, streak_d;

  logic [1:0]          grant_raw;
  grant_e              grant;
  logic                arb_cycle;
  logic                starved;

  // New work is only accepted where the main-TLB port is free next cycle.
  assign arb_cycle = (state_q == ST_IDLE) || (state_q == ST_RESP) ||
                     (state_q == ST_FLUSH);
  assign starved   = (streak_q == STRK_MAX);

  tlb_arb_prio u_prio (
    .op_req_i  (op_req_i),
    .op_i      (op_i),
    .dreq_i    (dreq_i),
    .ireq_i    (ireq_i),
    .starved_i (starved),
    .grant_o   (grant_raw)
  );

  assign grant = grant_e'(grant_raw);

  always_comb begin
    streak_d = streak_q;
    if (!ireq_i) begin
      streak_d = '0;
    end else if (arb_cycle && grant == GNT_INST) begin
      streak_d = '0;
    end else if (arb_cycle && grant == GNT_DATA && !starved) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: every register is cleared by the async reset so no response can
  // resume after release, and sequential state uses non-blocking assigns only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      side_q   <= SIDE_INST;
      vpn_q    <= '0;
      op_q     <= OP_NONE;
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
      unique case (state_q)
        ST_LOOKUP: state_q <= ST_RESP;
        ST_MAINT:  state_q <= ST_FLUSH;
        default: begin
          unique case (grant)
            GNT_OP: begin
              state_q <= ST_MAINT;
              op_q    <= tlb_op_e'(op_i);
            end
            GNT_DATA: begin
              state_q <= ST_LOOKUP;
              side_q  <= SIDE_DATA;
              vpn_q   <= dvpn_i;
            end
            GNT_INST: begin
              state_q <= ST_LOOKUP;
              side_q  <= SIDE_INST;
              vpn_q   <= ivpn_i;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      endcase
    end
  end

  logic in_resp;
  assign in_resp = (state_q == ST_RESP);

  assign tlb_lk_req_o = (state_q == ST_LOOKUP);
  assign tlb_lk_vpn_o = vpn_q;

  // Hit and result are the main-TLB answer passed straight through in RESP.
  assign i_done_o  = in_resp && (side_q == SIDE_INST);
  assign d_done_o  = in_resp && (side_q == SIDE_DATA);
  assign i_hit_o   = i_done_o && tlb_lk_hit_i;
  assign d_hit_o   = d_done_o && tlb_lk_hit_i;
  assign res_out_o = in_resp ? tlb_lk_res_i : '0;

  assign tlb_op_en_o  = (state_q == ST_MAINT);
  assign tlb_op_o     = (state_q == ST_MAINT) ? op_q : OP_NONE;
  assign utlb_flush_o = (state_q == ST_FLUSH);
  assign op_done_o    = (state_q == ST_FLUSH);
  assign op_busy_o    = (state_q == ST_MAINT) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Directed bench for tlb_refill_arbiter: inputs driven and outputs sampled
// on the falling edge, expected values hand-computed per scenario.
module tb_tlb_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, op_req = 1'b0;
  logic [19:0] ivpn = '0, dvpn = '0;
  logic [1:0]  op = '0;
  logic        tlb_lk_hit = 1'b0;
  logic [23:0] tlb_lk_res = '0;

  logic        i_done, i_hit, d_done, d_hit, op_busy, op_done;
  logic        tlb_lk_req, tlb_op_en, utlb_flush;
  logic [19:0] tlb_lk_vpn;
  logic [1:0]  tlb_op;
  logic [23:0] res_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlb_refill_arbiter #(.STARVE_LIMIT(3), .RES_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ireq_i       (ireq),
    .ivpn_i       (ivpn),
    .i_done_o     (i_done),
    .i_hit_o      (i_hit),
    .dreq_i       (dreq),
    .dvpn_i       (dvpn),
    .d_done_o     (d_done),
    .d_hit_o      (d_hit),
    .res_out_o    (res_out),
    .op_req_i     (op_req),
    .op_i         (op),
    .op_busy_o    (op_busy),
    .op_done_o    (op_done),
    .tlb_lk_req_o (tlb_lk_req),
    .tlb_lk_vpn_o (tlb_lk_vpn),
    .tlb_lk_hit_i (tlb_lk_hit),
    .tlb_lk_res_i (tlb_lk_res),
    .tlb_op_en_o  (tlb_op_en),
    .tlb_op_o     (tlb_op),
    .utlb_flush_o (utlb_flush)
  );

  // Packed control outputs: {lk_req, i_done, i_hit, d_done, d_hit, op_busy,
  // op_en, tlb_op[1:0], flush, op_done}
  logic [10:0] ctl;
  assign ctl = {tlb_lk_req, i_done, i_hit, d_done, d_hit, op_busy,
                tlb_op_en, tlb_op, utlb_flush, op_done};

  localparam logic [10:0] C_LK     = 11'b100_0000_0000;
  localparam logic [10:0] C_IDONE  = 11'b010_0000_0000;
  localparam logic [10:0] C_IHIT   = 11'b001_0000_0000;
  localparam logic [10:0] C_DDONE  = 11'b000_1000_0000;
  localparam logic [10:0] C_DHIT   = 11'b000_0100_0000;
  localparam logic [10:0] C_BUSY   = 11'b000_0010_0000;
  localparam logic [10:0] C_OPEN   = 11'b000_0001_0000;
  localparam logic [10:0] C_OPWI   = 11'b000_0000_0100;
  localparam logic [10:0] C_OPWR   = 11'b000_0000_1000;
  localparam logic [10:0] C_FLUSH  = 11'b000_0000_0010;
  localparam logic [10:0] C_OPDONE = 11'b000_0000_0001;
  localparam logic [10:0] C_ZERO   = 11'b000_0000_0000;

  task automatic test_reset();
    rst_n = 1'b0;
    tlb_lk_hit = 1'b1; tlb_lk_res = 24'hABCDE7;
    ireq = 1'b1; ivpn = 20'h12345; dreq = 1'b1; dvpn = 20'h54321;
    op_req = 1'b1; op = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== C_ZERO || res_out !== 24'h0 || tlb_lk_vpn !== 20'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d ctl=%b res=%h vpn=%h expected all zero",
                 c, ctl, res_out, tlb_lk_vpn);
      end
    end
    // Release with only ireq pending: grant must happen at the very next edge.
    dreq = 1'b0; op_req = 1'b0; op = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_inst_lookup();
    @(negedge clk);
    total++;
    if (ctl !== C_LK || tlb_lk_vpn !== 20'h12345) begin
      bad++;
      $display("FAIL inst_lookup ctl=%b vpn=%h expected ctl=%b vpn=12345", ctl, tlb_lk_vpn, C_LK);
    end
    @(negedge clk);
    total++;
    if (ctl !== (C_IDONE | C_IHIT) || res_out !== 24'hABCDE7) begin
      bad++;
      $display("FAIL inst_resp ctl=%b res=%h expected ctl=%b res=abcde7", ctl, res_out, C_IDONE | C_IHIT);
    end
    ireq = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL inst_idle ctl=%b expected %b", ctl, C_ZERO);
    end
  endtask

  task automatic test_starvation();
    logic is_inst;
    tlb_lk_hit = 1'b0; tlb_lk_res = 24'h000111;
    ireq = 1'b1; ivpn = 20'h11111;
    dreq = 1'b1; dvpn = 20'h22222;
    for (int g = 0; g < 8; g++) begin
      is_inst = (g % 4 == 3);
      @(negedge clk);
      total++;
      if (ctl !== C_LK || tlb_lk_vpn !== (is_inst ? 20'h11111 : 20'h22222)) begin
        bad++;
        $display("FAIL starve_grant%0d ctl=%b vpn=%h expected %s", g, ctl, tlb_lk_vpn,
                 is_inst ? "inst 11111" : "data 22222");
      end
      @(negedge clk);
      total++;
      if (ctl !== (is_inst ? C_IDONE : C_DDONE) || res_out !== 24'h000111) begin
        bad++;
        $display("FAIL starve_resp%0d ctl=%b res=%h expected ctl=%b", g, ctl, res_out,
                 is_inst ? C_IDONE : C_DDONE);
      end
      if (g == 7) begin
        ireq = 1'b0; dreq = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL starve_idle ctl=%b expected %b", ctl, C_ZERO);
    end
  endtask

  task automatic test_op_during_lookup();
    tlb_lk_hit = 1'b1; tlb_lk_res = 24'h0F0F0F;
    dreq = 1'b1; dvpn = 20'h0ABCD;
    @(negedge clk);
    total++;
    if (ctl !== C_LK || tlb_lk_vpn !== 20'h0ABCD) begin
      bad++;
      $display("FAIL opl_lookup ctl=%b vpn=%h expected ctl=%b vpn=0abcd", ctl, tlb_lk_vpn, C_LK);
    end
    op_req = 1'b1; op = 2'b10;
    @(negedge clk);
    total++;
    if (ctl !== (C_DDONE | C_DHIT) || res_out !== 24'h0F0F0F) begin
      bad++;
      $display("FAIL opl_resp ctl=%b res=%h expected ctl=%b", ctl, res_out, C_DDONE | C_DHIT);
    end
    dreq = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== (C_BUSY | C_OPEN | C_OPWR)) begin
      bad++;
      $display("FAIL opl_maint ctl=%b expected %b", ctl, C_BUSY | C_OPEN | C_OPWR);
    end
    @(negedge clk);
    total++;
    if (ctl !== (C_BUSY | C_FLUSH | C_OPDONE)) begin
      bad++;
      $display("FAIL opl_flush ctl=%b expected %b", ctl, C_BUSY | C_FLUSH | C_OPDONE);
    end
    op_req = 1'b0; op = 2'b00;
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL opl_idle ctl=%b expected %b", ctl, C_ZERO);
    end
  endtask

  task automatic test_op_before_data();
    tlb_lk_hit = 1'b0;
    op_req = 1'b1; op = 2'b01;
    dreq = 1'b1; dvpn = 20'h33333;
    @(negedge clk);
    total++;
    if (ctl !== (C_BUSY | C_OPEN | C_OPWI)) begin
      bad++;
      $display("FAIL opd_maint ctl=%b expected %b", ctl, C_BUSY | C_OPEN | C_OPWI);
    end
    @(negedge clk);
    total++;
    if (ctl !== (C_BUSY | C_FLUSH | C_OPDONE)) begin
      bad++;
      $display("FAIL opd_flush ctl=%b expected %b", ctl, C_BUSY | C_FLUSH | C_OPDONE);
    end
    op_req = 1'b0; op = 2'b00;
    @(negedge clk);
    total++;
    if (ctl !== C_LK || tlb_lk_vpn !== 20'h33333) begin
      bad++;
      $display("FAIL opd_back_to_back ctl=%b vpn=%h expected ctl=%b vpn=33333", ctl, tlb_lk_vpn, C_LK);
    end
    @(negedge clk);
    total++;
    if (ctl !== C_DDONE) begin
      bad++;
      $display("FAIL opd_resp ctl=%b expected %b", ctl, C_DDONE);
    end
    dreq = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL opd_idle ctl=%b expected %b", ctl, C_ZERO);
    end
  endtask

  task automatic test_reset_mid();
    tlb_lk_res = 24'h777777;
    dreq = 1'b1; dvpn = 20'h55555;
    @(negedge clk);
    total++;
    if (ctl !== C_LK) begin
      bad++;
      $display("FAIL rstl_lookup ctl=%b expected %b", ctl, C_LK);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== C_ZERO || res_out !== 24'h0 || tlb_lk_vpn !== 20'h0) begin
      bad++;
      $display("FAIL rstl_immediate ctl=%b res=%h vpn=%h expected all zero", ctl, res_out, tlb_lk_vpn);
    end
    dreq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== C_ZERO) begin
        bad++;
        $display("FAIL rstl_no_late_done cycle=%0d ctl=%b expected %b", c, ctl, C_ZERO);
      end
    end
    // Same again with a maintenance op in flight.
    op_req = 1'b1; op = 2'b11;
    @(negedge clk);
    total++;
    if (ctl !== (C_BUSY | C_OPEN | C_OPWI | C_OPWR)) begin
      bad++;
      $display("FAIL rstm_maint ctl=%b expected %b", ctl, C_BUSY | C_OPEN | C_OPWI | C_OPWR);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL rstm_immediate ctl=%b expected %b", ctl, C_ZERO);
    end
    op_req = 1'b0; op = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== C_ZERO) begin
        bad++;
        $display("FAIL rstm_no_late_done cycle=%0d ctl=%b expected %b", c, ctl, C_ZERO);
      end
    end
  endtask

  task automatic test_op_none();
    tlb_lk_hit = 1'b1; tlb_lk_res = 24'h123456;
    op_req = 1'b1; op = 2'b00;
    ireq = 1'b1; ivpn = 20'h66666;
    @(negedge clk);
    total++;
    if (ctl !== C_LK || tlb_lk_vpn !== 20'h66666) begin
      bad++;
      $display("FAIL opnone_lookup ctl=%b vpn=%h expected ctl=%b vpn=66666", ctl, tlb_lk_vpn, C_LK);
    end
    @(negedge clk);
    total++;
    if (ctl !== (C_IDONE | C_IHIT) || res_out !== 24'h123456) begin
      bad++;
      $display("FAIL opnone_resp ctl=%b res=%h expected ctl=%b", ctl, res_out, C_IDONE | C_IHIT);
    end
    ireq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== C_ZERO) begin
        bad++;
        $display("FAIL opnone_ignored cycle=%0d ctl=%b expected %b", c, ctl, C_ZERO);
      end
    end
    op_req = 1'b0;
  endtask

  task automatic test_cancel();
    @(negedge clk);
    dreq = 1'b1; dvpn = 20'h44444;
    #2 dreq = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL cancel_data ctl=%b expected %b", ctl, C_ZERO);
    end
    op_req = 1'b1; op = 2'b01;
    #2 op_req = 1'b0;
    @(negedge clk);
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("FAIL cancel_op ctl=%b expected %b", ctl, C_ZERO);
    end
    op = 2'b00;
  endtask

  initial begin
    test_reset();
    test_inst_lookup();
    test_starvation();
    test_op_during_lookup();
    test_op_before_data();
    test_reset_mid();
    test_op_none();
    test_cancel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t expected bench to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
